// File: rtl/qr_frame_loader.sv
// qr_frame_loader
//   Upstream feeder for the QR / back-substitution top level. Packs a
//   valid/ready element stream, four elements per row, into a two-bank
//   ping-pong frame store. Each complete frame is replayed as one contiguous
//   burst of NUM_ROWS row words. Bursts are separated by at least GAP_CYCLES
//   idle cycles, because downstream starts a new frame on the first valid
//   cycle that follows a low cycle.
//
// Ports
//   Clk        rising-edge clock
//   Reset      synchronous, active-high; discards all buffered data
//   s_valid    upstream element valid
//   s_ready    loader can take an element (write bank not full)
//   s_data     signed element, row-major, 4 per row
//   OutValid   row valid, high for NUM_ROWS consecutive cycles per frame
//   OutData1-4 row elements 0..3 (OutData1 = first accepted of the row)
//   frame_cnt  frames emitted, modulo 256
module qr_frame_loader #(
    parameter int C_IWL      = 5,
    parameter int C_FWL      = 15,
    parameter int NUM_ROWS   = 4,
    parameter int GAP_CYCLES = 1,
    localparam int W         = C_IWL + C_FWL
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [W-1:0] s_data,
    output logic                OutValid,
    output logic signed [W-1:0] OutData1,
    output logic signed [W-1:0] OutData2,
    output logic signed [W-1:0] OutData3,
    output logic signed [W-1:0] OutData4,
    output logic [7:0]          frame_cnt
);

    localparam int NEL = 4 * NUM_ROWS;
    localparam int EPW = $clog2(NEL);
    localparam int RW  = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

    logic signed [W-1:0] r_mem [2][NEL];
    logic                r_wb;
    logic                r_rb;
    logic [1:0]          r_full;
    logic [EPW-1:0]      r_ep;
    logic [RW-1:0]       r_row;
    logic [7:0]          r_gap;
    state_t              r_state;

    logic                w_accept;
    logic [EPW-1:0]      w_rbase;

    // Ready depends only on state (and Reset), never on s_valid.
    assign s_ready  = !Reset && !r_full[r_wb];
    assign w_accept = s_valid && s_ready;
    // Element address of column 0 of the row being replayed.
    assign w_rbase  = {r_row, 2'b00};

    // Frame store: no reset needed, validity is tracked by r_full.
    always_ff @(posedge Clk) begin
        if (w_accept)
            r_mem[r_wb][r_ep] <= s_data;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wb      <= 1'b0;
            r_rb      <= 1'b0;
            r_full    <= 2'b00;
            r_ep      <= '0;
            r_row     <= '0;
            r_gap     <= 8'd0;
            r_state   <= S_IDLE;
            OutValid  <= 1'b0;
            OutData1  <= '0;
            OutData2  <= '0;
            OutData3  <= '0;
            OutData4  <= '0;
            frame_cnt <= 8'd0;
        end else begin
            // Write side. Writes never target the bank being read (it is full),
            // so the set below and the clear in BURST always touch different bits.
            if (w_accept) begin
                if (r_ep == EPW'(NEL - 1)) begin
                    r_full[r_wb] <= 1'b1;
                    r_ep         <= '0;
                    r_wb         <= ~r_wb;
                end else begin
                    r_ep <= r_ep + EPW'(1);
                end
            end

            // Read side.
            case (r_state)
                S_IDLE: begin
                    OutValid <= 1'b0;
                    if (r_full[r_rb]) begin
                        r_state <= S_BURST;
                        r_row   <= '0;
                    end
                end
                S_BURST: begin
                    OutValid <= 1'b1;
                    OutData1 <= r_mem[r_rb][w_rbase];
                    OutData2 <= r_mem[r_rb][w_rbase + EPW'(1)];
                    OutData3 <= r_mem[r_rb][w_rbase + EPW'(2)];
                    OutData4 <= r_mem[r_rb][w_rbase + EPW'(3)];
                    if (r_row == RW'(NUM_ROWS - 1)) begin
                        r_full[r_rb] <= 1'b0;
                        r_rb         <= ~r_rb;
                        frame_cnt    <= frame_cnt + 8'd1;
                        r_gap        <= 8'(GAP_CYCLES);
                        r_state      <= S_GAP;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end
                S_GAP: begin
                    OutValid <= 1'b0;
                    // Final gap cycle folds in the IDLE decision so back-to-back
                    // frames see exactly GAP_CYCLES low cycles.
                    if (r_gap <= 8'd1) begin
                        r_gap <= 8'd0;
                        if (r_full[r_rb]) begin
                            r_state <= S_BURST;
                            r_row   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qr_frame_loader.sv
// Randomized bench for qr_frame_loader. The reference model is a queue of
// accepted elements: every 16 accepted elements form a frame whose elements
// must reappear, four per output cycle, in the same order.
module tb_qr_frame_loader;

    localparam int W   = 20;
    localparam int NR  = 4;
    localparam int GAP = 24;
    localparam int NEL = 4 * NR;

    logic                Clk = 1'b0;
    logic                Reset;
    logic                s_valid;
    logic                s_ready;
    logic signed [W-1:0] s_data;
    logic                OutValid;
    logic signed [W-1:0] OutData1, OutData2, OutData3, OutData4;
    logic [7:0]          frame_cnt;

    qr_frame_loader #(
        .C_IWL(5), .C_FWL(15), .NUM_ROWS(NR), .GAP_CYCLES(GAP)
    ) dut (
        .Clk(Clk), .Reset(Reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .OutValid(OutValid), .OutData1(OutData1),
        .OutData2(OutData2), .OutData3(OutData3), .OutData4(OutData4),
        .frame_cnt(frame_cnt)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;
    int edge_n = 0;
    logic signed [W-1:0] part_q[$];
    logic signed [W-1:0] exp_q[$];
    int completed, emitted, run, low_run, t_done;
    bit prev_burst, lat_chk, last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        part_q.delete();
        exp_q.delete();
        completed  = 0;
        emitted    = 0;
        run        = 0;
        low_run    = 0;
        prev_burst = 0;
        lat_chk    = 0;
    endtask

    // Observes outputs #1 after an edge.
    task automatic monitor(input bit was_rst);
        logic signed [W-1:0] e[4];
        if (was_rst) begin
            chk("rst_valid", OutValid, 0);
            chk("rst_fcnt", frame_cnt, 0);
            chk("rst_d1", OutData1, 0);
            chk("rst_d4", OutData4, 0);
            return;
        end
        if (OutValid) begin
            if (run == 0) begin
                if (prev_burst) chk("gap_min", low_run >= GAP, 1);
                if (lat_chk) begin
                    chk("latency", edge_n - t_done, 2);
                    lat_chk = 0;
                end
            end
            if (exp_q.size() < 4) begin
                chk("spurious_row", 1, 0);
            end else begin
                for (int i = 0; i < 4; i++) e[i] = exp_q.pop_front();
                chk("d1", OutData1, e[0]);
                chk("d2", OutData2, e[1]);
                chk("d3", OutData3, e[2]);
                chk("d4", OutData4, e[3]);
            end
            run++;
            if (run == NR) emitted++;
        end else begin
            if (run > 0) begin
                chk("burst_len", run, NR);
                prev_burst = 1;
                low_run    = 0;
                run        = 0;
            end
            low_run++;
        end
        chk("fcnt", frame_cnt, emitted % 256);
    endtask

    task automatic cyc(input bit v, input logic signed [W-1:0] d, input bit rst = 0);
        bit acc;
        Reset   = rst;
        s_valid = v;
        s_data  = d;
        #1;
        if (rst) chk("rdy_rst", s_ready, 0);
        else     chk("rdy", s_ready, (completed - emitted) < 2);
        acc = v && s_ready && !rst;
        @(posedge Clk);
        edge_n++;
        if (rst) begin
            model_reset();
        end else if (acc) begin
            part_q.push_back(d);
            if (part_q.size() == NEL) begin
                foreach (part_q[i]) exp_q.push_back(part_q[i]);
                part_q.delete();
                completed++;
                t_done = edge_n;
            end
        end
        last_acc = acc;
        #1;
        monitor(rst);
    endtask

    // Feed n elements with the given bubble percentage; neg puts -1.0 and the
    // most-negative value in the first two elements.
    task automatic send(input int n, input int bub, input bit neg = 0);
        int fed = 0;
        int k = 0;
        logic signed [W-1:0] d;
        while (fed < n && k < n * 10 + 200) begin
            d = W'($urandom);
            if (neg && fed == 0) d = 20'shF8000;
            if (neg && fed == 1) d = 20'sh80000;
            cyc($urandom_range(99) >= bub, d);
            if (last_acc) fed++;
            k++;
        end
        if (fed < n) chk("send_timeout", fed, n);
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while ((completed != emitted || run != 0 || exp_q.size() != 0) && k < maxc) begin
            cyc(0, '0);
            k++;
        end
        if (k >= maxc) chk("drain_timeout", 1, 0);
        repeat (4) cyc(0, '0);
    endtask

    initial begin
        bit found;
        int fed;
        model_reset();

        // Reset, then elements 1..16 scaled by 2^15, back to back.
        cyc(0, '0, 1);
        cyc(0, '0, 1);
        lat_chk = 1;
        for (int i = 1; i <= 16; i++) cyc(1, W'(i << 15));
        drain(200);
        chk("t1_fcnt", frame_cnt, 1);

        // Three frames streamed continuously; banks fill and s_ready drops.
        send(48, 0);
        drain(400);
        chk("t2_fcnt", frame_cnt, 4);

        // Sign preservation.
        send(16, 0, 1);
        drain(200);

        // 50% bubbles over five frames.
        send(80, 50);
        drain(400);
        chk("t4_fcnt", frame_cnt, 10);

        // Reset on the 3rd burst cycle with a second frame buffered.
        cyc(0, '0, 1);
        found = 0;
        fed   = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            cyc(fed < 64, W'($urandom));
            if (last_acc) fed++;
            if (OutValid && run == 3 && (completed - emitted) >= 2) found = 1;
        end
        if (!found) chk("rst_trigger_timeout", 1, 0);
        cyc(1, W'($urandom), 1);
        repeat (40) cyc(0, '0);
        chk("t5_fcnt", frame_cnt, 0);
        lat_chk = 1;
        send(16, 0);
        drain(200);
        chk("t5_fresh_fcnt", frame_cnt, 1);

        // 256 frames: frame_cnt wraps to 0.
        cyc(0, '0, 1);
        send(256 * NEL, 0);
        drain(400);
        chk("wrap_fcnt", frame_cnt, 0);
        chk("wrap_emitted", emitted, 256);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
